// File: rtl/rv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv_ctrl_pkg
//  Description : Shared opcodes, FSM state codes and datapath select codes
//                for the multi-cycle RV32I main control.
//  Revision    : 1.0  initial release
// ============================================================================
package rv_ctrl_pkg;

    localparam logic [6:0] c_OP_LOAD   = 7'h03;
    localparam logic [6:0] c_OP_STORE  = 7'h23;
    localparam logic [6:0] c_OP_RTYPE  = 7'h33;
    localparam logic [6:0] c_OP_ITYPE  = 7'h13;
    localparam logic [6:0] c_OP_BRANCH = 7'h63;
    localparam logic [6:0] c_OP_LUI    = 7'h37;
    localparam logic [6:0] c_OP_AUIPC  = 7'h17;
    localparam logic [6:0] c_OP_JAL    = 7'h6F;
    localparam logic [6:0] c_OP_JALR   = 7'h67;

    localparam logic [2:0] c_ST_FETCH     = 3'd0;
    localparam logic [2:0] c_ST_DECODE    = 3'd1;
    localparam logic [2:0] c_ST_EXECUTE   = 3'd2;
    localparam logic [2:0] c_ST_MEMORY    = 3'd3;
    localparam logic [2:0] c_ST_WRITEBACK = 3'd4;
    localparam logic [2:0] c_ST_TRAP      = 3'd5;

    localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] c_ALUOP_BR    = 2'b01;
    localparam logic [1:0] c_ALUOP_ARITH = 2'b10;

    localparam logic [1:0] c_RES_ALU = 2'b00;
    localparam logic [1:0] c_RES_MEM = 2'b01;
    localparam logic [1:0] c_RES_PC4 = 2'b10;

    localparam logic [2:0] c_IMM_NONE = 3'b000;
    localparam logic [2:0] c_IMM_I    = 3'b001;
    localparam logic [2:0] c_IMM_S    = 3'b010;
    localparam logic [2:0] c_IMM_B    = 3'b011;
    localparam logic [2:0] c_IMM_U    = 3'b100;
    localparam logic [2:0] c_IMM_J    = 3'b101;

endpackage
`default_nettype wire

// File: rtl/rv_main_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : rv_main_decoder
//  Description : Combinational RV32I opcode decode into datapath selects and
//                instruction-class flags.
//  Revision    : 1.0  initial release
// ============================================================================
module rv_main_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output logic       legal,
    output logic       ALUSrc,
    output logic       ALUSrc_pc,
    output logic [1:0] ALUOp,
    output logic [1:0] ResultSrc,
    output logic [2:0] imm_sel,
    output logic       is_ld,
    output logic       is_st,
    output logic       is_br,
    output logic       is_jmp
);

    always_comb begin
        legal     = 1'b1;
        ALUSrc    = 1'b0;
        ALUSrc_pc = 1'b0;
        ALUOp     = c_ALUOP_ADD;
        ResultSrc = c_RES_ALU;
        imm_sel   = c_IMM_NONE;
        is_ld     = 1'b0;
        is_st     = 1'b0;
        is_br     = 1'b0;
        is_jmp    = 1'b0;
        case (op)
            c_OP_LOAD: begin
                ALUSrc    = 1'b1;
                ResultSrc = c_RES_MEM;
                imm_sel   = c_IMM_I;
                is_ld     = 1'b1;
            end
            c_OP_STORE: begin
                ALUSrc  = 1'b1;
                imm_sel = c_IMM_S;
                is_st   = 1'b1;
            end
            c_OP_RTYPE: begin
                ALUOp = c_ALUOP_ARITH;
            end
            c_OP_ITYPE: begin
                ALUSrc  = 1'b1;
                ALUOp   = c_ALUOP_ARITH;
                imm_sel = c_IMM_I;
            end
            c_OP_BRANCH: begin
                ALUOp   = c_ALUOP_BR;
                imm_sel = c_IMM_B;
                is_br   = 1'b1;
            end
            c_OP_LUI: begin
                ALUSrc  = 1'b1;
                imm_sel = c_IMM_U;
            end
            c_OP_AUIPC: begin
                ALUSrc    = 1'b1;
                ALUSrc_pc = 1'b1;
                imm_sel   = c_IMM_U;
            end
            c_OP_JAL: begin
                ALUSrc    = 1'b1;
                ALUSrc_pc = 1'b1;
                ResultSrc = c_RES_PC4;
                imm_sel   = c_IMM_J;
                is_jmp    = 1'b1;
            end
            c_OP_JALR: begin
                ALUSrc    = 1'b1;
                ResultSrc = c_RES_PC4;
                imm_sel   = c_IMM_I;
                is_jmp    = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rv_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rv_multicycle_ctrl
//  Description : Multi-cycle RV32I main control FSM with memory handshakes,
//                bounded-wait timeout, sticky fault and retire counter.
//  Revision    : 1.0  initial release
// ============================================================================
module rv_multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32,
    parameter int TO_W        = 8
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             ALUSrc,
    output logic             ALUSrc_pc,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ResultSrc,
    output logic [2:0]       imm_sel,
    output logic             fault,
    output logic             instr_retired,
    output logic [CNT_W-1:0] retire_count
);

    localparam logic [TO_W-1:0] c_TIMEOUT = TO_W'(MEM_TIMEOUT);
    localparam logic            c_TO_EN   = (MEM_TIMEOUT != 0);

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [6:0]       r_op_q;
    logic [TO_W-1:0]  r_wait_cnt;
    logic [CNT_W-1:0] r_retire_cnt;

    logic [6:0] w_dec_op;
    logic       w_legal, w_alu_src, w_alu_src_pc;
    logic [1:0] w_alu_op, w_result_src;
    logic [2:0] w_imm_sel;
    logic       w_is_ld, w_is_st, w_is_br, w_is_jmp;
    logic       w_timeout;

    // The IR opcode is only latched at the end of DECODE, so legality is
    // judged on the live field during that one cycle.
    assign w_dec_op  = (r_state == c_ST_DECODE) ? op : r_op_q;
    assign w_timeout = c_TO_EN && (r_wait_cnt == c_TIMEOUT);

    rv_main_decoder u_dec (
        .op        (w_dec_op),
        .legal     (w_legal),
        .ALUSrc    (w_alu_src),
        .ALUSrc_pc (w_alu_src_pc),
        .ALUOp     (w_alu_op),
        .ResultSrc (w_result_src),
        .imm_sel   (w_imm_sel),
        .is_ld     (w_is_ld),
        .is_st     (w_is_st),
        .is_br     (w_is_br),
        .is_jmp    (w_is_jmp)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_ST_FETCH;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_FETCH: begin
                if (imem_ready)     w_next = c_ST_DECODE;
                else if (w_timeout) w_next = c_ST_TRAP;
            end
            c_ST_DECODE: w_next = w_legal ? c_ST_EXECUTE : c_ST_TRAP;
            c_ST_EXECUTE: begin
                if (w_is_ld || w_is_st) w_next = c_ST_MEMORY;
                else if (w_is_br)       w_next = c_ST_FETCH;
                else                    w_next = c_ST_WRITEBACK;
            end
            c_ST_MEMORY: begin
                if (dmem_ready)     w_next = w_is_st ? c_ST_FETCH : c_ST_WRITEBACK;
                else if (w_timeout) w_next = c_ST_TRAP;
            end
            c_ST_WRITEBACK: w_next = c_ST_FETCH;
            c_ST_TRAP:      w_next = c_ST_TRAP;
            default:        w_next = c_ST_FETCH;
        endcase
    end

    // Reset gates every output so an access cut short by rst never strobes.
    always_comb begin
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        ir_we         = 1'b0;
        pc_we         = 1'b0;
        pc_sel        = 1'b0;
        RegWrite      = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        ALUSrc        = 1'b0;
        ALUSrc_pc     = 1'b0;
        ALUOp         = c_ALUOP_ADD;
        ResultSrc     = c_RES_ALU;
        imm_sel       = c_IMM_NONE;
        fault         = 1'b0;
        instr_retired = 1'b0;
        if (!rst) begin
            case (r_state)
                c_ST_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ready;
                end
                c_ST_EXECUTE: begin
                    if (w_is_br) begin
                        pc_we         = 1'b1;
                        pc_sel        = branch_taken;
                        instr_retired = 1'b1;
                    end
                end
                c_ST_MEMORY: begin
                    dmem_req = 1'b1;
                    MemRead  = w_is_ld;
                    MemWrite = w_is_st;
                    if (dmem_ready && w_is_st) begin
                        pc_we         = 1'b1;
                        instr_retired = 1'b1;
                    end
                end
                c_ST_WRITEBACK: begin
                    RegWrite      = 1'b1;
                    pc_we         = 1'b1;
                    pc_sel        = w_is_jmp;
                    instr_retired = 1'b1;
                end
                c_ST_TRAP: fault = 1'b1;
                default: ;
            endcase
            if (r_state inside {c_ST_EXECUTE, c_ST_MEMORY, c_ST_WRITEBACK}) begin
                ALUSrc    = w_alu_src;
                ALUSrc_pc = w_alu_src_pc;
                ALUOp     = w_alu_op;
                ResultSrc = w_result_src;
                imm_sel   = w_imm_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_q       <= 7'd0;
            r_wait_cnt   <= '0;
            r_retire_cnt <= '0;
        end else begin
            if (r_state == c_ST_DECODE) r_op_q <= op;
            // Staying in FETCH/MEMORY implies ready was low this cycle.
            if (w_next != r_state)
                r_wait_cnt <= '0;
            else if (r_state == c_ST_FETCH || r_state == c_ST_MEMORY)
                r_wait_cnt <= r_wait_cnt + TO_W'(1);
            if (instr_retired) r_retire_cnt <= r_retire_cnt + CNT_W'(1);
        end
    end

    assign retire_count = r_retire_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rv_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv_multicycle_ctrl
//  Description : Directed vector bench for rv_multicycle_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rv_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic       branch_taken, imem_ready, dmem_ready;
    logic       imem_req, dmem_req, ir_we, pc_we, pc_sel, RegWrite, MemRead, MemWrite;
    logic       ALUSrc, ALUSrc_pc, fault, instr_retired;
    logic [1:0] ALUOp, ResultSrc;
    logic [2:0] imm_sel;
    logic [3:0] retire_count;

    always #5 clk = ~clk;

    rv_multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4), .TO_W(8)) dut (
        .clk(clk), .rst(rst), .op(op), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .ir_we(ir_we), .pc_we(pc_we),
        .pc_sel(pc_sel), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .ALUSrc(ALUSrc), .ALUSrc_pc(ALUSrc_pc), .ALUOp(ALUOp), .ResultSrc(ResultSrc),
        .imm_sel(imm_sel), .fault(fault), .instr_retired(instr_retired),
        .retire_count(retire_count)
    );

    // {imem,dmem,ir_we,pc_we,pc_sel,RegWrite,MemRead,MemWrite,ALUSrc,ALUSrc_pc}_ALUOp_ResultSrc_imm_{fault,retired}
    logic [18:0] w_got;
    assign w_got = {imem_req, dmem_req, ir_we, pc_we, pc_sel, RegWrite, MemRead, MemWrite,
                    ALUSrc, ALUSrc_pc, ALUOp, ResultSrc, imm_sel, fault, instr_retired};

    localparam logic [18:0] c_F_RDY  = 19'b1010000000_00_00_000_00;
    localparam logic [18:0] c_F_WAIT = 19'b1000000000_00_00_000_00;
    localparam logic [18:0] c_NONE   = 19'b0000000000_00_00_000_00;
    localparam logic [18:0] c_FAULT  = 19'b0000000000_00_00_000_10;

    typedef struct {
        logic [6:0]  op;
        logic        bt, ir, dr;
        logic [18:0] exp;
        logic [3:0]  cnt;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [6:0] o, input logic b, input logic i, input logic d);
        rst = r; op = o; branch_taken = b; imem_ready = i; dmem_ready = d;
        @(negedge clk);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic row(input logic [6:0] o, input logic b, input logic i, input logic d,
                       input logic [18:0] e, input logic [3:0] c);
        vec_t v;
        v.op = o; v.bt = b; v.ir = i; v.dr = d; v.exp = e; v.cnt = c;
        tbl.push_back(v);
    endtask

    task automatic do_reset;
        drive(1'b1, 7'h00, 1'b0, 1'b1, 1'b1);
        tick;
    endtask

    // Zero-wait ADD; checks the running count at its FETCH cycle.
    task automatic run_add(input logic [3:0] exp_cnt, input int k);
        drive(1'b0, 7'h00, 1'b0, 1'b1, 1'b0);
        check($sformatf("wrap_cnt[%0d]", k), 32'(retire_count), 32'(exp_cnt));
        tick;
        drive(1'b0, 7'h33, 1'b0, 1'b0, 1'b0); tick;
        drive(1'b0, 7'h00, 1'b0, 1'b0, 1'b0); tick;
        drive(1'b0, 7'h00, 1'b0, 1'b0, 1'b0); tick;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; op = 7'h00; branch_taken = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        tick; tick;

        drive(1'b1, 7'h00, 1'b0, 1'b1, 1'b1);
        check("reset_outputs", 32'(w_got), 32'(c_NONE));
        check("reset_count", 32'(retire_count), 32'd0);
        tick;

        // ADD
        row(7'h00,0,1,0, c_F_RDY, 0); row(7'h33,0,0,0, c_NONE, 0);
        row(7'h00,0,0,0, 19'b0000000000_10_00_000_00, 0);
        row(7'h00,0,0,0, 19'b0001010000_10_00_000_01, 0);
        // LW, dmem ready on 4th MEMORY cycle
        row(7'h00,0,1,0, c_F_RDY, 1); row(7'h03,0,0,0, c_NONE, 1);
        row(7'h00,0,0,0, 19'b0000000010_00_01_001_00, 1);
        row(7'h00,0,0,0, 19'b0100001010_00_01_001_00, 1);
        row(7'h00,0,0,0, 19'b0100001010_00_01_001_00, 1);
        row(7'h00,0,0,0, 19'b0100001010_00_01_001_00, 1);
        row(7'h00,0,0,1, 19'b0100001010_00_01_001_00, 1);
        row(7'h00,0,0,0, 19'b0001010010_00_01_001_01, 1);
        // BEQ taken / not taken
        row(7'h00,0,1,0, c_F_RDY, 2); row(7'h63,0,0,0, c_NONE, 2);
        row(7'h00,1,0,0, 19'b0001100000_01_00_011_01, 2);
        row(7'h00,0,1,0, c_F_RDY, 3); row(7'h63,0,0,0, c_NONE, 3);
        row(7'h00,0,0,0, 19'b0001000000_01_00_011_01, 3);
        // SW zero-wait
        row(7'h00,0,1,0, c_F_RDY, 4); row(7'h23,0,0,0, c_NONE, 4);
        row(7'h00,0,0,0, 19'b0000000010_00_00_010_00, 4);
        row(7'h00,0,0,1, 19'b0101000110_00_00_010_01, 4);
        // JAL
        row(7'h00,0,1,0, c_F_RDY, 5); row(7'h6F,0,0,0, c_NONE, 5);
        row(7'h00,0,0,0, 19'b0000000011_00_10_101_00, 5);
        row(7'h00,0,0,0, 19'b0001110011_00_10_101_01, 5);
        // JALR
        row(7'h00,0,1,0, c_F_RDY, 6); row(7'h67,0,0,0, c_NONE, 6);
        row(7'h00,0,0,0, 19'b0000000010_00_10_001_00, 6);
        row(7'h00,0,0,0, 19'b0001110010_00_10_001_01, 6);
        // AUIPC
        row(7'h00,0,1,0, c_F_RDY, 7); row(7'h17,0,0,0, c_NONE, 7);
        row(7'h00,0,0,0, 19'b0000000011_00_00_100_00, 7);
        row(7'h00,0,0,0, 19'b0001010011_00_00_100_01, 7);
        // LUI
        row(7'h00,0,1,0, c_F_RDY, 8); row(7'h37,0,0,0, c_NONE, 8);
        row(7'h00,0,0,0, 19'b0000000010_00_00_100_00, 8);
        row(7'h00,0,0,0, 19'b0001010010_00_00_100_01, 8);
        // ADDI, imem ready arrives exactly at the timeout count
        row(7'h00,0,0,0, c_F_WAIT, 9); row(7'h00,0,0,0, c_F_WAIT, 9);
        row(7'h00,0,0,0, c_F_WAIT, 9); row(7'h00,0,0,0, c_F_WAIT, 9);
        row(7'h00,0,1,0, c_F_RDY, 9); row(7'h13,0,0,0, c_NONE, 9);
        row(7'h00,0,0,0, 19'b0000000010_10_00_001_00, 9);
        row(7'h00,0,0,0, 19'b0001010010_10_00_001_01, 9);

        foreach (tbl[i]) begin
            drive(1'b0, tbl[i].op, tbl[i].bt, tbl[i].ir, tbl[i].dr);
            check($sformatf("tbl[%0d].out", i), 32'(w_got), 32'(tbl[i].exp));
            check($sformatf("tbl[%0d].cnt", i), 32'(retire_count), 32'(tbl[i].cnt));
            tick;
        end

        // Reset in the middle of a store's MEMORY wait
        drive(1'b0, 7'h00, 1'b0, 1'b1, 1'b0); tick;
        drive(1'b0, 7'h23, 1'b0, 1'b0, 1'b0); tick;
        drive(1'b0, 7'h00, 1'b0, 1'b0, 1'b0); tick;
        drive(1'b0, 7'h00, 1'b0, 1'b0, 1'b0);
        check("rst_mem_wait", 32'(w_got), 32'(19'b0100000110_00_00_010_00));
        check("rst_mem_cnt_before", 32'(retire_count), 32'd10);
        tick;
        drive(1'b1, 7'h00, 1'b0, 1'b0, 1'b1);
        check("rst_mem_gated", 32'(w_got), 32'(c_NONE));
        tick;
        drive(1'b0, 7'h00, 1'b0, 1'b0, 1'b1);
        check("rst_mem_fetch", 32'(w_got), 32'(c_F_WAIT));
        check("rst_mem_cnt_after", 32'(retire_count), 32'd0);
        tick;

        // Illegal opcode traps and stays trapped
        do_reset;
        drive(1'b0, 7'h00, 1'b0, 1'b1, 1'b0); tick;
        drive(1'b0, 7'h7F, 1'b0, 1'b0, 1'b0);
        check("illegal_decode", 32'(w_got), 32'(c_NONE));
        tick;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 7'h33, 1'b1, 1'b1, 1'b1);
            check($sformatf("illegal_trap[%0d]", k), 32'(w_got), 32'(c_FAULT));
            tick;
        end
        do_reset;
        drive(1'b0, 7'h00, 1'b0, 1'b0, 1'b0);
        check("fault_cleared", 32'(w_got), 32'(c_F_WAIT));
        tick;

        // Fetch timeout: 5 FETCH cycles, then TRAP
        do_reset;
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 7'h00, 1'b0, 1'b0, 1'b0);
            check($sformatf("fetch_wait[%0d]", k), 32'(w_got), 32'(c_F_WAIT));
            tick;
        end
        drive(1'b0, 7'h00, 1'b0, 1'b1, 1'b0);
        check("fetch_timeout", 32'(w_got), 32'(c_FAULT));
        tick;

        // Data-memory timeout on a load
        do_reset;
        drive(1'b0, 7'h00, 1'b0, 1'b1, 1'b0); tick;
        drive(1'b0, 7'h03, 1'b0, 1'b0, 1'b0); tick;
        drive(1'b0, 7'h00, 1'b0, 1'b0, 1'b0); tick;
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 7'h00, 1'b0, 1'b0, 1'b0);
            check($sformatf("dmem_wait[%0d]", k), 32'(w_got), 32'(19'b0100001010_00_01_001_00));
            tick;
        end
        drive(1'b0, 7'h00, 1'b0, 1'b0, 1'b1);
        check("dmem_timeout", 32'(w_got), 32'(c_FAULT));
        tick;

        // Retire counter wraps after 16 instructions with CNT_W=4
        do_reset;
        for (int k = 0; k < 16; k++) run_add(4'(k), k);
        drive(1'b0, 7'h00, 1'b0, 1'b0, 1'b0);
        check("wrap_final", 32'(retire_count), 32'd0);
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
